// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle for the multicycle control unit.
// The master side is the controller; the slave side is the datapath and memory.
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_branch;
    logic [1:0] aluop;
    logic       alu_src;
    logic       reg_write;
    logic       mem2reg;
    logic       illegal;
    logic       mem_err;
    logic [2:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_branch, aluop, alu_src,
               reg_write, mem2reg, illegal, mem_err, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_branch, aluop, alu_src,
               reg_write, mem2reg, illegal, mem_err, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// per-access memory wait timeout (MAX_WAIT = 0 disables the timeout).
module multicycle_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);

    localparam int unsigned CntW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ClsR  = 3'd0,
        ClsLd = 3'd1,
        ClsI  = 3'd2,
        ClsS  = 3'd3,
        ClsB  = 3'd4
    } cls_e;

    state_e          state_q, state_d;
    cls_e            cls_q, cls_d;
    logic [CntW-1:0] wait_q, wait_d;

    cls_e            dec_cls;
    logic            dec_valid;
    logic [1:0]      cls_aluop;
    logic            cls_alu_src;
    logic            timeout;
    logic [CntW-1:0] wait_inc;

    always_comb begin
        dec_cls   = ClsR;
        dec_valid = 1'b1;
        case (bus.opcode)
            7'b0110011: dec_cls = ClsR;
            7'b0000011: dec_cls = ClsLd;
            7'b0010011: dec_cls = ClsI;
            7'b0100011: dec_cls = ClsS;
            7'b1100011: dec_cls = ClsB;
            default:    dec_valid = 1'b0;
        endcase
    end

    always_comb begin
        cls_aluop   = 2'b00;
        cls_alu_src = 1'b0;
        case (cls_q)
            ClsR:    begin cls_aluop = 2'b10; cls_alu_src = 1'b0; end
            ClsLd:   begin cls_aluop = 2'b00; cls_alu_src = 1'b1; end
            ClsI:    begin cls_aluop = 2'b11; cls_alu_src = 1'b1; end
            ClsS:    begin cls_aluop = 2'b00; cls_alu_src = 1'b1; end
            ClsB:    begin cls_aluop = 2'b01; cls_alu_src = 1'b0; end
            default: begin cls_aluop = 2'b00; cls_alu_src = 1'b0; end
        endcase
    end

    // Ready in the limit cycle wins over the timeout.
    assign timeout  = (MAX_WAIT != 0) && (wait_q == CntW'(MAX_WAIT)) && !bus.mem_ready;
    assign wait_inc = (wait_q == {CntW{1'b1}}) ? wait_q : wait_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        wait_d        = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.iord      = 1'b0;
        bus.ir_write  = 1'b0;
        bus.pc_write  = 1'b0;
        bus.pc_branch = 1'b0;
        bus.aluop     = 2'b00;
        bus.alu_src   = 1'b0;
        bus.reg_write = 1'b0;
        bus.mem2reg   = 1'b0;
        bus.illegal   = 1'b0;
        bus.mem_err   = 1'b0;
        bus.state     = 3'd0;

        if (!rst) begin
            bus.state = state_q;
            case (state_q)
                StFetch: begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        state_d      = StDecode;
                    end else if (timeout) begin
                        bus.mem_err = 1'b1;
                    end else begin
                        wait_d = wait_inc;
                    end
                end
                StDecode: begin
                    if (dec_valid) begin
                        cls_d   = dec_cls;
                        state_d = StExec;
                    end else begin
                        bus.illegal = 1'b1;
                        state_d     = StFetch;
                    end
                end
                StExec: begin
                    bus.aluop   = cls_aluop;
                    bus.alu_src = cls_alu_src;
                    case (cls_q)
                        ClsR, ClsI:  state_d = StWb;
                        ClsLd, ClsS: state_d = StMem;
                        default: begin
                            bus.pc_branch = bus.zero;
                            state_d       = StFetch;
                        end
                    endcase
                end
                StMem: begin
                    bus.aluop   = cls_aluop;
                    bus.alu_src = cls_alu_src;
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                    bus.mem_we  = (cls_q == ClsS);
                    if (bus.mem_ready) begin
                        state_d = (cls_q == ClsLd) ? StWb : StFetch;
                    end else if (timeout) begin
                        bus.mem_err = 1'b1;
                        state_d     = StFetch;
                    end else begin
                        wait_d = wait_inc;
                    end
                end
                StWb: begin
                    bus.reg_write = 1'b1;
                    bus.mem2reg   = (cls_q == ClsLd);
                    state_d       = StFetch;
                end
                default: begin
                    bus.state = 3'd0;
                    state_d   = StFetch;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            cls_q   <= ClsR;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
        end
    end

endmodule
